// File: rtl/bp_be_dcache_port_arbiter.sv
// D$ port arbiter between the integer pipeline and the page-table walker.
// Grants are combinational. Each accepted request is tracked for two cycles
// (stage1: ptag phase, stage2: early-response phase) so ptag and early
// response traffic can be steered back to the requester that owns it.
// Optional feature: define BP_BE_DCACHE_ARB_RR_EN to round-robin contested
// grants; when undefined the PTW always wins a contention.

package bp_be_dcache_port_arbiter_pkg;
  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int page_offset_width_gp  = 12;
  localparam int dpath_width_gp        = 64;
  localparam int dcache_opcode_width_gp = 5;

  // Physical tag width for a given processor configuration.
  function automatic int ptag_width_of(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 28;
      default:          return 28;
    endcase
  endfunction
endpackage

`ifndef BP_BE_DCACHE_PKT_WIDTH
  `define BP_BE_DCACHE_PKT_WIDTH(page_offset_mp, dpath_mp) (dcache_opcode_width_gp + (page_offset_mp) + (dpath_mp))
`endif

module bp_be_dcache_port_arbiter
  import bp_be_dcache_port_arbiter_pkg::*;
#(
  parameter bp_params_e bp_params_p  = e_bp_default_cfg,
  parameter int         pkt_width_p  = `BP_BE_DCACHE_PKT_WIDTH(page_offset_width_gp, dpath_width_gp),
  parameter int         ptag_width_p = ptag_width_of(bp_params_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,

  input  logic                    pipe_v_i,
  input  logic [pkt_width_p-1:0]  pipe_pkt_i,
  input  logic [ptag_width_p-1:0] pipe_ptag_i,
  input  logic                    pipe_ptag_v_i,
  output logic                    pipe_yumi_o,

  input  logic                    ptw_v_i,
  input  logic [pkt_width_p-1:0]  ptw_pkt_i,
  input  logic [ptag_width_p-1:0] ptw_ptag_i,
  input  logic                    ptw_ptag_v_i,
  input  logic                    ptw_lock_i,
  output logic                    ptw_yumi_o,

  output logic                    dcache_v_o,
  output logic [pkt_width_p-1:0]  dcache_pkt_o,
  output logic [ptag_width_p-1:0] dcache_ptag_o,
  output logic                    dcache_ptag_v_o,
  input  logic                    dcache_ready_i,
  input  logic                    dcache_early_v_i,

  output logic                    pipe_early_v_o,
  output logic                    ptw_early_v_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {e_idle, e_ptw_own, e_drain} state_e;

  state_e     state_r, state_n;
  // Index 1 = ptag phase, index 2 = early-response phase.
  logic [2:1] vld_pipe;
  logic [2:1] own_ptw;

  logic pipe_stage_v, ptw_stage_v;
  logic pipe_req, ptw_req, contested, ptw_wins;
  logic pipe_gnt, ptw_gnt;

  assign pipe_stage_v = |(vld_pipe & ~own_ptw);
  assign ptw_stage_v  = |(vld_pipe &  own_ptw);

  // A flush kills the pipeline request in the same cycle; reset masks both.
  assign pipe_req  = pipe_v_i & ~flush_i & ~reset_i;
  assign ptw_req   = ptw_v_i & ~reset_i;
  assign contested = pipe_req & ptw_req & ~pipe_stage_v;

`ifdef BP_BE_DCACHE_ARB_RR_EN
  logic rr_ptw_r;
  assign ptw_wins = rr_ptw_r;

  // Priority pointer hands the next contested grant to the loser of this one.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_ptw_r <= 1'b1;
    else if ((state_r == e_idle) && contested && dcache_ready_i)
      rr_ptw_r <= ~rr_ptw_r;
  end
`else
  assign ptw_wins = 1'b1;
`endif

  // Grant selection and ownership FSM next state.
  always_comb begin
    pipe_gnt = 1'b0;
    ptw_gnt  = 1'b0;
    state_n  = state_r;
    unique case (state_r)
      e_idle: begin
        if (ptw_req && pipe_stage_v) begin
          // PTW must wait for the pipeline's in-flight accesses to retire.
          state_n = e_drain;
        end else if (ptw_req && !(contested && !ptw_wins)) begin
          ptw_gnt = 1'b1;
          if (ptw_lock_i) state_n = e_ptw_own;
        end else begin
          pipe_gnt = pipe_req;
        end
      end
      e_ptw_own: begin
        ptw_gnt = ptw_req;
        if (!ptw_lock_i && !ptw_stage_v) state_n = e_idle;
      end
      e_drain: begin
        // Stage2 is refilled from stage1, so a non-pipe stage1 means empty next cycle.
        if (!(vld_pipe[1] && !own_ptw[1]) || flush_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // State and two-stage ownership tracking; flush drops pipe-owned stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      vld_pipe <= '0;
      own_ptw  <= '0;
    end else begin
      state_r     <= state_n;
      vld_pipe[1] <= (pipe_gnt | ptw_gnt) & dcache_ready_i;
      own_ptw[1]  <= ptw_gnt;
      vld_pipe[2] <= vld_pipe[1] & ~(flush_i & ~own_ptw[1]);
      own_ptw[2]  <= own_ptw[1];
    end
  end

  assign pipe_yumi_o = pipe_gnt & dcache_ready_i;
  assign ptw_yumi_o  = ptw_gnt & dcache_ready_i;
  assign dcache_v_o  = pipe_gnt | ptw_gnt;
  assign dcache_pkt_o = ptw_gnt  ? ptw_pkt_i  :
                        pipe_gnt ? pipe_pkt_i : '0;

  assign dcache_ptag_o   = (reset_i || !vld_pipe[1]) ? '0 :
                           own_ptw[1] ? ptw_ptag_i : pipe_ptag_i;
  assign dcache_ptag_v_o = (reset_i || !vld_pipe[1]) ? 1'b0 :
                           own_ptw[1] ? ptw_ptag_v_i : pipe_ptag_v_i;

  assign pipe_early_v_o = dcache_early_v_i & vld_pipe[2] & ~own_ptw[2] & ~reset_i;
  assign ptw_early_v_o  = dcache_early_v_i & vld_pipe[2] &  own_ptw[2] & ~reset_i;
  assign busy_o         = ~reset_i & ((state_r != e_idle) | (|vld_pipe));

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// Bench for bp_be_dcache_port_arbiter: directed scenarios with literal
// expectations plus a long random run against a cycle-level reference model.
module tb_bp_be_dcache_port_arbiter;
  localparam int PKT_W  = 81;
  localparam int PTAG_W = 28;
  localparam int NONE = 0, PIPE = 1, PTW = 2;
  localparam int M_IDLE = 0, M_OWN = 1, M_DRAIN = 2;
`ifdef BP_BE_DCACHE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i, flush_i, pipe_v_i, pipe_ptag_v_i, ptw_v_i, ptw_ptag_v_i, ptw_lock_i;
  logic dcache_ready_i, dcache_early_v_i;
  logic [PKT_W-1:0]  pipe_pkt_i, ptw_pkt_i, dcache_pkt_o;
  logic [PTAG_W-1:0] pipe_ptag_i, ptw_ptag_i, dcache_ptag_o;
  logic pipe_yumi_o, ptw_yumi_o, dcache_v_o, dcache_ptag_v_o;
  logic pipe_early_v_o, ptw_early_v_o, busy_o;
  logic [95:0] rnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_be_dcache_port_arbiter #(.pkt_width_p(PKT_W), .ptag_width_p(PTAG_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .pipe_v_i(pipe_v_i), .pipe_pkt_i(pipe_pkt_i), .pipe_ptag_i(pipe_ptag_i),
    .pipe_ptag_v_i(pipe_ptag_v_i), .pipe_yumi_o(pipe_yumi_o),
    .ptw_v_i(ptw_v_i), .ptw_pkt_i(ptw_pkt_i), .ptw_ptag_i(ptw_ptag_i),
    .ptw_ptag_v_i(ptw_ptag_v_i), .ptw_lock_i(ptw_lock_i), .ptw_yumi_o(ptw_yumi_o),
    .dcache_v_o(dcache_v_o), .dcache_pkt_o(dcache_pkt_o), .dcache_ptag_o(dcache_ptag_o),
    .dcache_ptag_v_o(dcache_ptag_v_o), .dcache_ready_i(dcache_ready_i),
    .dcache_early_v_i(dcache_early_v_i), .pipe_early_v_o(pipe_early_v_o),
    .ptw_early_v_o(ptw_early_v_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: current mode plus the owner of each request accepted
  // one (h1) and two (h2) cycles ago.
  int mode = M_IDLE;
  int h1 = NONE;
  int h2 = NONE;
  bit rr_ptw = 1'b1;

  always @(negedge clk) begin
    bit gp, gw, pr, wr, pipe_busy, ptw_busy, both;
    bit e_ptag_v, e_pe, e_we, e_busy;
    int nmode;
    logic [PKT_W-1:0]  e_pkt;
    logic [PTAG_W-1:0] e_ptag;
    gp = 0; gw = 0; both = 0; nmode = mode;
    e_pkt = '0; e_ptag = '0; e_ptag_v = 0; e_pe = 0; e_we = 0; e_busy = 0;
    pr = pipe_v_i && !flush_i;
    wr = ptw_v_i;
    pipe_busy = (h1 == PIPE) || (h2 == PIPE);
    ptw_busy  = (h1 == PTW)  || (h2 == PTW);
    if (!reset_i) begin
      case (mode)
        M_IDLE: begin
          if (wr && pipe_busy) nmode = M_DRAIN;
          else begin
            both = wr && pr;
            if (wr && (!pr || !RR_EN || rr_ptw)) gw = 1;
            else if (pr) gp = 1;
            if (gw && ptw_lock_i) nmode = M_OWN;
          end
        end
        M_OWN: begin
          gw = wr;
          if (!ptw_lock_i && !ptw_busy) nmode = M_IDLE;
        end
        default: if (h1 != PIPE || flush_i) nmode = M_IDLE;
      endcase
      e_pkt = gw ? ptw_pkt_i : gp ? pipe_pkt_i : '0;
      if (h1 == PTW)       {e_ptag_v, e_ptag} = {ptw_ptag_v_i, ptw_ptag_i};
      else if (h1 == PIPE) {e_ptag_v, e_ptag} = {pipe_ptag_v_i, pipe_ptag_i};
      e_pe = dcache_early_v_i && (h2 == PIPE);
      e_we = dcache_early_v_i && (h2 == PTW);
      e_busy = (mode != M_IDLE) || (h1 != NONE) || (h2 != NONE);
    end
    chk("pipe_yumi", 128'(pipe_yumi_o), 128'(gp && dcache_ready_i));
    chk("ptw_yumi", 128'(ptw_yumi_o), 128'(gw && dcache_ready_i));
    chk("dcache_v", 128'(dcache_v_o), 128'(gp || gw));
    chk("dcache_pkt", 128'(dcache_pkt_o), 128'(e_pkt));
    chk("dcache_ptag", 128'(dcache_ptag_o), 128'(e_ptag));
    chk("dcache_ptag_v", 128'(dcache_ptag_v_o), 128'(e_ptag_v));
    chk("pipe_early", 128'(pipe_early_v_o), 128'(e_pe));
    chk("ptw_early", 128'(ptw_early_v_o), 128'(e_we));
    chk("busy", 128'(busy_o), 128'(e_busy));
    if (reset_i) begin
      mode = M_IDLE; h1 = NONE; h2 = NONE; rr_ptw = 1'b1;
    end else begin
      if (both && dcache_ready_i) rr_ptw = !rr_ptw;
      h2 = (h1 == PIPE && flush_i) ? NONE : h1;
      h1 = !dcache_ready_i ? NONE : gw ? PTW : gp ? PIPE : NONE;
      mode = nmode;
    end
  end

  task automatic idle_inputs();
    flush_i = 0; pipe_v_i = 0; pipe_ptag_v_i = 0; ptw_v_i = 0; ptw_ptag_v_i = 0;
    ptw_lock_i = 0; dcache_ready_i = 1; dcache_early_v_i = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_i = 1; idle_inputs();
    next(); next();
    reset_i = 0;
  endtask

  initial begin
    reset_i = 1; idle_inputs();
    pipe_pkt_i = '0; ptw_pkt_i = '0; pipe_ptag_i = '0; ptw_ptag_i = '0;
    pipe_pkt_i[15:0] = 16'h1111; ptw_pkt_i[15:0] = 16'h2222;
    next(); next();
    #1 chk("reset_busy", 128'(busy_o), 128'(0));
    chk("reset_dcache_v", 128'(dcache_v_o), 128'(0));

    // Pipe access: yumi at N, ptag at N+1, early response at N+2.
    do_reset();
    pipe_v_i = 1;
    #1 chk("s1_pipe_yumi", 128'(pipe_yumi_o), 128'(1));
    chk("s1_pkt", 128'(dcache_pkt_o[15:0]), 128'(16'h1111));
    next(); pipe_v_i = 0; pipe_ptag_v_i = 1; pipe_ptag_i = 28'h0abcdef;
    #1 chk("s1_ptag_v", 128'(dcache_ptag_v_o), 128'(1));
    chk("s1_ptag", 128'(dcache_ptag_o), 128'(28'h0abcdef));
    next(); pipe_ptag_v_i = 0; dcache_early_v_i = 1;
    #1 chk("s1_pipe_early", 128'(pipe_early_v_o), 128'(1));
    chk("s1_ptw_early", 128'(ptw_early_v_o), 128'(0));
    next(); dcache_early_v_i = 0;

    // PTW arrives behind a pipe access: drain, then grant at N+3.
    do_reset();
    pipe_v_i = 1;
    #1 chk("s2_pipe_yumi", 128'(pipe_yumi_o), 128'(1));
    next(); pipe_v_i = 0; ptw_v_i = 1;
    #1 chk("s2_ptw_wait1", 128'(ptw_yumi_o), 128'(0));
    next();
    #1 chk("s2_ptw_wait2", 128'(ptw_yumi_o), 128'(0));
    chk("s2_busy", 128'(busy_o), 128'(1));
    next();
    #1 chk("s2_ptw_yumi", 128'(ptw_yumi_o), 128'(1));
    next(); ptw_v_i = 0; next(); next();

    // Locked walk: pipe locked out until the lock drops with PTW stages empty.
    do_reset();
    ptw_v_i = 1; ptw_lock_i = 1; pipe_v_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s3_ptw_yumi", 128'(ptw_yumi_o), 128'(1));
      chk("s3_pipe_blocked", 128'(pipe_yumi_o), 128'(0));
      next();
    end
    ptw_v_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("s3_pipe_held", 128'(pipe_yumi_o), 128'(0));
      next();
    end
    ptw_lock_i = 0;
    #1 chk("s3_pipe_unlock_cycle", 128'(pipe_yumi_o), 128'(0));
    next();
    #1 chk("s3_pipe_after_unlock", 128'(pipe_yumi_o), 128'(1));
    next(); pipe_v_i = 0;

    // Flush suppresses the early response of an in-flight pipe access.
    do_reset();
    pipe_v_i = 1;
    #1 chk("s4_pipe_yumi", 128'(pipe_yumi_o), 128'(1));
    next(); pipe_v_i = 0; flush_i = 1;
    next(); flush_i = 0; dcache_early_v_i = 1;
    #1 chk("s4_pipe_early_flushed", 128'(pipe_early_v_o), 128'(0));
    chk("s4_ptw_early", 128'(ptw_early_v_o), 128'(0));
    next(); dcache_early_v_i = 0;

    // Contention with stages clear between attempts.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bit exp_ptw;
      pipe_v_i = 1; ptw_v_i = 1;
      exp_ptw = RR_EN ? (k % 2 == 0) : 1'b1;
      #1 chk("s5_ptw_win", 128'(ptw_yumi_o), 128'(exp_ptw));
      chk("s5_pipe_win", 128'(pipe_yumi_o), 128'(!exp_ptw));
      next(); pipe_v_i = 0; ptw_v_i = 0;
      next(); next(); next();
    end

    // Reset while the PTW owns the port.
    do_reset();
    ptw_v_i = 1; ptw_lock_i = 1;
    next();
    reset_i = 1; dcache_early_v_i = 1; ptw_ptag_v_i = 1;
    #1 chk("s6_rst_ptw_yumi", 128'(ptw_yumi_o), 128'(0));
    chk("s6_rst_dcache_v", 128'(dcache_v_o), 128'(0));
    chk("s6_rst_ptag_v", 128'(dcache_ptag_v_o), 128'(0));
    chk("s6_rst_busy", 128'(busy_o), 128'(0));
    next(); reset_i = 0; ptw_v_i = 0; ptw_lock_i = 0;
    #1 chk("s6_busy", 128'(busy_o), 128'(0));
    chk("s6_ptw_early", 128'(ptw_early_v_o), 128'(0));
    chk("s6_pipe_early", 128'(pipe_early_v_o), 128'(0));
    chk("s6_ptag_v", 128'(dcache_ptag_v_o), 128'(0));
    next(); idle_inputs();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      reset_i          = ($urandom_range(0, 99) == 0);
      flush_i          = ($urandom_range(0, 7) == 0);
      pipe_v_i         = ($urandom_range(0, 1) == 1);
      ptw_v_i          = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ptw_lock_i = !ptw_lock_i;
      dcache_ready_i   = ($urandom_range(0, 3) != 0);
      dcache_early_v_i = ($urandom_range(0, 1) == 1);
      pipe_ptag_v_i    = ($urandom_range(0, 1) == 1);
      ptw_ptag_v_i     = ($urandom_range(0, 1) == 1);
      pipe_ptag_i      = PTAG_W'($urandom);
      ptw_ptag_i       = PTAG_W'($urandom);
      rnd = {$urandom, $urandom, $urandom};
      pipe_pkt_i = rnd[PKT_W-1:0];
      rnd = {$urandom, $urandom, $urandom};
      ptw_pkt_i = rnd[PKT_W-1:0];
      next();
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_be_dcache_port_arbiter.md
BP_BE_DCACHE_PORT_ARBITER -- requirements
Module: bp_be_dcache_port_arbiter

Interface
REQ-001 Parameter bp_params_p, default e_bp_default_cfg; processor configuration.
REQ-002 Parameter pkt_width_p, default `bp_be_dcache_pkt_width(page_offset_width_gp, dpath_width_gp); D$ packet width.
REQ-003 Parameter ptag_width_p, default from bp_params_p; physical tag width.
REQ-004 Ports:
- clk_i  in  1  the one clock.
- reset_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush.
- pipe_v_i  in  1  pipeline request valid.
- pipe_pkt_i  in  pkt_width_p  pipeline packet.
- pipe_ptag_i  in  ptag_width_p  pipeline ptag, one cycle after grant.
- pipe_ptag_v_i  in  1  pipeline ptag valid.
- pipe_yumi_o  out  1  pipeline request accepted.
- ptw_v_i  in  1  PTW request valid.
- ptw_pkt_i  in  pkt_width_p  PTW packet.
- ptw_ptag_i  in  ptag_width_p  PTW ptag.
- ptw_ptag_v_i  in  1  PTW ptag valid.
- ptw_lock_i  in  1  PTW holds the port across a walk.
- ptw_yumi_o  out  1  PTW request accepted.
- dcache_v_o  out  1  packet valid to D$.
- dcache_pkt_o  out  pkt_width_p  packet to D$.
- dcache_ptag_o  out  ptag_width_p  ptag to D$.
- dcache_ptag_v_o  out  1  ptag valid to D$.
- dcache_ready_i  in  1  D$ can accept.
- dcache_early_v_i  in  1  D$ early response valid.
- pipe_early_v_o  out  1  early response belongs to pipeline.
- ptw_early_v_o  out  1  early response belongs to PTW.
- busy_o  out  1  state not IDLE or any stage valid.

Function
REQ-005 Grants are combinational; yumi_o = grant & dcache_ready_i, at most one yumi per cycle.
REQ-006 dcache_v_o/dcache_pkt_o come from the granted requester; pkt_o is 0 when there is no grant.
REQ-007 On a grant in cycle N, the arbiter records the owner in stage1 (valid, owner) for N+1 and in stage2 for N+2.
REQ-008 In N+1, dcache_ptag_o/ptag_v_o are muxed from the stage1 owner; both are 0 if stage1 is invalid.
REQ-009 In N+2, pipe_early_v_o = dcache_early_v_i & stage2 valid & owner==pipe; ptw_early_v_o is the same with owner==PTW.
REQ-010 FSM states: IDLE, PTW_OWN, DRAIN.
REQ-011 IDLE with ptw_v_i & pipe stages empty: grant PTW; if ptw_lock_i is also set, go to PTW_OWN.
REQ-012 IDLE with ptw_v_i & a pipe-owned stage valid: no grant; go to DRAIN.
REQ-013 DRAIN: no grants; move to IDLE when no pipe-owned stage is valid (at most 2 cycles).
REQ-014 PTW_OWN: only PTW can be granted; return to IDLE on the cycle ptw_lock_i=0 and no PTW stage is valid.
REQ-015 pipe_v_i alone in IDLE: grant pipe.
REQ-016 Both requesting in IDLE with pipe stages empty: priority per REQ-023.
REQ-017 flush_i clears pipe-owned stage1/stage2 valids next cycle; pipe_early_v_o is suppressed for those requests; PTW-owned stages are unaffected.
REQ-018 flush_i blocks pipe grants in the same cycle; it does not block PTW.
REQ-019 dcache_ready_i=0: no yumi and no stage advance for a new request; in-flight stages still shift.

Reset
REQ-020 reset_i high at a clock edge: state=IDLE and stage1/stage2 valids cleared.
REQ-021 While reset_i is high, every output is 0; the round-robin pointer is set to PTW.
REQ-022 Reset mid-walk or mid-drain discards all ownership; no early_v_o is asserted on the following cycle.

Configuration
REQ-023 Macro BP_BE_DCACHE_ARB_RR_EN:
- Defined: on a contention per REQ-016, priority round-robins; the pointer flips to the other requester after each contested grant.
- Undefined: on a contention per REQ-016, the PTW always wins.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- pipe_v_i=1, ready=1, ptag_v=1 at N+1, early_v=1 at N+2 -> pipe_yumi_o at N, dcache_ptag_v_o at N+1, pipe_early_v_o=1 at N+2, ptw_early_v_o=0.
- Pipe granted at N, ptw_v_i=1 at N+1 -> DRAIN at N+1..N+2, ptw_yumi_o at N+3.
- ptw_v_i and ptw_lock_i held for 3 accesses with pipe_v_i=1 throughout -> pipe_yumi_o=0 until the cycle after ptw_lock_i drops.
- Pipe granted at N, flush_i at N+1, early_v=1 at N+2 -> pipe_early_v_o=0.
- Both requesting 4 cycles, stages clear -> RR_EN grants alternate PTW, pipe, PTW, pipe; without RR_EN, PTW wins all 4.
- reset_i asserted in PTW_OWN -> all outputs 0 and busy_o=0 the next cycle.
